// File: rtl/spec_free_list_pkg.sv
// Shared sizes, tag/pointer types and the modular pointer add for the speculative free list.
// The depth is not a power of two, so every pointer wrap goes through fl_add.
package spec_free_list_pkg;

  localparam int DISPATCH_WIDTH      = 4;
  localparam int COMMIT_WIDTH        = 4;
  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_RMT            = 34;
  localparam int SIZE_FREE_LIST      = SIZE_PHYSICAL_TABLE - SIZE_RMT;

  localparam int SIZE_FREE_LIST_LOG  = $clog2(SIZE_FREE_LIST);
  localparam int SIZE_PHYSICAL_LOG   = $clog2(SIZE_PHYSICAL_TABLE);
  localparam int DISPATCH_WIDTH_LOG  = $clog2(DISPATCH_WIDTH);
  localparam int COMMIT_WIDTH_LOG    = $clog2(COMMIT_WIDTH);

  typedef logic [SIZE_PHYSICAL_LOG-1:0]  phys_reg_t;
  typedef logic [SIZE_FREE_LIST_LOG-1:0] fl_ptr_t;
  typedef logic [SIZE_FREE_LIST_LOG:0]   fl_cnt_t;
  typedef logic [DISPATCH_WIDTH_LOG:0]   pop_cnt_t;
  typedef logic [COMMIT_WIDTH_LOG:0]     commit_cnt_t;

  localparam fl_cnt_t FL_DEPTH = fl_cnt_t'(SIZE_FREE_LIST);

  // ptr and n are each below the depth, so a single conditional subtract suffices
  function automatic fl_ptr_t fl_add(input fl_ptr_t ptr, input fl_ptr_t n);
    fl_cnt_t sum;
    sum = {1'b0, ptr} + {1'b0, n};
    if (sum >= FL_DEPTH) begin
      sum = sum - FL_DEPTH;
    end
    return sum[SIZE_FREE_LIST_LOG-1:0];
  endfunction

endpackage

// File: rtl/spec_free_list_if.sv
// Rename-side and commit-side signals of the free list.
// master drives pops/pushes/flush; slave is the free list itself.
interface spec_free_list_if
  import spec_free_list_pkg::*;
();

  logic                                popEn_i;
  pop_cnt_t                            popCount_i;
  phys_reg_t [0:DISPATCH_WIDTH-1]      free_phys_o;
  logic                                freeListEmpty_o;
  logic      [COMMIT_WIDTH-1:0]        freedValid_i;
  phys_reg_t [0:COMMIT_WIDTH-1]        freedPhyReg_i;
  commit_cnt_t                         commitDestCount_i;
  logic                                recoverFlag_i;
  fl_cnt_t                             freeCount_o;

  modport master (
    output popEn_i, popCount_i, freedValid_i, freedPhyReg_i, commitDestCount_i, recoverFlag_i,
    input  free_phys_o, freeListEmpty_o, freeCount_o
  );

  modport slave (
    input  popEn_i, popCount_i, freedValid_i, freedPhyReg_i, commitDestCount_i, recoverFlag_i,
    output free_phys_o, freeListEmpty_o, freeCount_o
  );

endinterface

// File: rtl/spec_free_list_push_compact.sv
// Exclusive prefix sum over the retire-lane valids: per-lane write offset from tail, plus total.
// Purely combinational, no backpressure (retire pushes are always accepted).
module free_list_push_compact
  import spec_free_list_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0] i_valid,
  output commit_cnt_t             o_offset [COMMIT_WIDTH],
  output commit_cnt_t             o_push_count
);

  commit_cnt_t w_run;

  always_comb begin
    w_run = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      o_offset[l] = w_run;
      w_run       = w_run + commit_cnt_t'(i_valid[l]);
    end
    o_push_count = w_run;
  end

endmodule

// File: rtl/spec_free_list.sv
// Circular speculative free list of physical tags: head read combinationally, pop/push/recover on the edge.
// No stall output other than freeListEmpty_o; pushes are never refused.
module spec_free_list
  import spec_free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  spec_free_list_if.slave      fl
);

  phys_reg_t r_entry [SIZE_FREE_LIST];
  fl_ptr_t   r_head;
  fl_ptr_t   r_tail;
  fl_ptr_t   r_arch_head;
  fl_cnt_t   r_free_count;
  fl_cnt_t   r_arch_count;

  commit_cnt_t w_offset [COMMIT_WIDTH];
  commit_cnt_t w_push_count;
  fl_ptr_t     w_wr_idx [COMMIT_WIDTH];
  logic        w_pop_fire;
  fl_cnt_t     w_pop_n;
  fl_cnt_t     w_push_n;
  fl_cnt_t     w_commit_n;
  fl_ptr_t     w_head_nxt;
  fl_ptr_t     w_tail_nxt;
  fl_ptr_t     w_arch_head_nxt;
  fl_cnt_t     w_free_count_nxt;
  fl_cnt_t     w_arch_count_nxt;
  fl_cnt_t     w_occ;

  free_list_push_compact u_push_compact (
    .i_valid      (fl.freedValid_i),
    .o_offset     (w_offset),
    .o_push_count (w_push_count)
  );

  // Head window depends on registered state only
  always_comb begin
    fl.free_phys_o = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      fl.free_phys_o[k] = r_entry[fl_add(r_head, fl_ptr_t'(k))];
    end
    fl.freeListEmpty_o = (r_free_count < fl_cnt_t'(DISPATCH_WIDTH));
    fl.freeCount_o     = r_free_count;
  end

  always_comb begin
    w_pop_fire       = fl.popEn_i && !fl.recoverFlag_i;
    w_pop_n          = w_pop_fire ? fl_cnt_t'(fl.popCount_i) : '0;
    w_push_n         = fl_cnt_t'(w_push_count);
    w_commit_n       = fl_cnt_t'(fl.commitDestCount_i);
    w_arch_head_nxt  = fl_add(r_arch_head, fl_ptr_t'(fl.commitDestCount_i));
    w_arch_count_nxt = r_arch_count - w_commit_n + w_push_n;
    w_tail_nxt       = fl_add(r_tail, fl_ptr_t'(w_push_count));
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      w_wr_idx[l] = fl_add(r_tail, fl_ptr_t'(w_offset[l]));
    end
    // A flush rolls back to the committed view, including this cycle's retirements
    if (fl.recoverFlag_i) begin
      w_head_nxt       = w_arch_head_nxt;
      w_free_count_nxt = w_arch_count_nxt;
    end else begin
      w_head_nxt       = fl_add(r_head, fl_ptr_t'(w_pop_n));
      w_free_count_nxt = r_free_count - w_pop_n + w_push_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SIZE_FREE_LIST; i++) begin
        r_entry[i] <= phys_reg_t'(SIZE_RMT + i);
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_arch_head  <= '0;
      r_free_count <= FL_DEPTH;
      r_arch_count <= FL_DEPTH;
    end else begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (fl.freedValid_i[l]) begin
          r_entry[w_wr_idx[l]] <= fl.freedPhyReg_i[l];
        end
      end
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_arch_head  <= w_arch_head_nxt;
      r_free_count <= w_free_count_nxt;
      r_arch_count <= w_arch_count_nxt;
    end
  end

  // tail == head is ambiguous between empty and full; the count disambiguates
  always_comb begin
    w_occ = '0;
    if (r_tail >= r_head) begin
      w_occ = {1'b0, r_tail} - {1'b0, r_head};
    end else begin
      w_occ = {1'b0, r_tail} + FL_DEPTH - {1'b0, r_head};
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(fl.popEn_i && fl.freeListEmpty_o));
      assert (r_free_count + w_push_n <= FL_DEPTH);
      assert (r_arch_count >= w_commit_n);
      assert (r_free_count <= r_arch_count);
      assert ((w_occ == '0) ? (r_free_count == '0 || r_free_count == FL_DEPTH)
                            : (r_free_count == w_occ));
    end
  end

endmodule
